// File: rtl/ahb_exp_mailbox_pkg.sv
// Shared constants for the AHB expansion-port mailbox: register offsets,
// STAT/CTRL bit positions and the data-phase response states.
package ahb_exp_mailbox_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_CLR  = 2'd3;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_TX_EMPTY = 1;
    localparam int STAT_RX_FULL  = 2;
    localparam int STAT_RX_EMPTY = 3;
    localparam int STAT_TX_OVF   = 4;
    localparam int STAT_RX_UNF   = 5;
    localparam int STAT_TX_LVL   = 8;
    localparam int STAT_RX_LVL   = 16;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;
    localparam int CTRL_TX_FLUSH  = 2;
    localparam int CTRL_RX_FLUSH  = 3;

    typedef enum logic [1:0] {
        DP_OKAY = 2'd0,
        DP_ERR1 = 2'd1,
        DP_ERR2 = 2'd2
    } dp_state_t;

    function automatic logic is_word(input logic [2:0] hsize);
        return hsize == SIZE_WORD;
    endfunction

endpackage

// File: rtl/ahb_exp_fifo.sv
// Synchronous FIFO with flush; pointers carry one extra wrap bit so that
// full and empty are distinguishable without a separate counter.
module ahb_exp_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DATA_W-1:0]        head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ahb_exp_mailbox.sv
// AHB-Lite target on the expansion port: CPU-to-fabric TX FIFO, fabric-to-CPU
// RX FIFO, status/control registers and a level interrupt.
//
//  state   | meaning
//  DP_OKAY | idle or word data phase, zero wait states
//  DP_ERR1 | first ERROR cycle for a non-word access, HREADYOUT low
//  DP_ERR2 | second ERROR cycle, HREADYOUT high
module ahb_exp_mailbox
    import ahb_exp_mailbox_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              FCLK,
    input  logic              MTXHRESETN,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADYMUX,
    output logic [31:0]       HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic              EXRESP,
    output logic [2:0]        HRUSER,
    output logic [DATA_W-1:0] TXDATA,
    output logic              TXVALID,
    input  logic              TXREADY,
    input  logic [DATA_W-1:0] RXDATA,
    input  logic              RXVALID,
    output logic              RXREADY,
    output logic              IRQ
);

    localparam int LW = $clog2(DEPTH) + 1;

    dp_state_t   state;
    dp_state_t   state_nxt;

    logic        acc;
    logic        dp_valid;
    logic        dp_write;
    logic        dp_word;
    logic [1:0]  dp_addr;
    logic        wr_fire;
    logic        rd_fire;

    logic        ctrl_rx_irq_en;
    logic        ctrl_tx_irq_en;
    logic        tx_ovf;
    logic        rx_unf;

    logic        tx_push;
    logic        tx_pop;
    logic        tx_flush;
    logic        tx_full;
    logic        tx_empty;
    logic [LW-1:0] tx_level;

    logic        rx_push;
    logic        rx_pop_req;
    logic        rx_pop;
    logic        rx_flush;
    logic        rx_full;
    logic        rx_empty;
    logic [LW-1:0] rx_level;
    logic [DATA_W-1:0] rx_head;

    logic        ctrl_wr;
    logic        clr_wr;
    logic        ovf_set;
    logic        unf_set;
    logic [31:0] stat_word;
    logic        unused_bits;

    assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

    assign EXRESP = 1'b0;
    assign HRUSER = 3'b000;

    assign acc = HSEL & HTRANS[1] & HREADYMUX;

    always_ff @(posedge FCLK or negedge MTXHRESETN) begin
        if (!MTXHRESETN) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_word  <= 1'b0;
            dp_addr  <= 2'd0;
        end else if (HREADYMUX) begin
            dp_valid <= acc;
            dp_write <= HWRITE;
            dp_word  <= is_word(HSIZE);
            dp_addr  <= HADDR[3:2];
        end
    end

    always_ff @(posedge FCLK or negedge MTXHRESETN) begin
        if (!MTXHRESETN) state <= DP_OKAY;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        case (state)
            DP_OKAY: begin
                if (acc && !is_word(HSIZE)) state_nxt = DP_ERR1;
            end
            DP_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_nxt = DP_ERR2;
            end
            DP_ERR2: begin
                HRESP     = 1'b1;
                state_nxt = (acc && !is_word(HSIZE)) ? DP_ERR1 : DP_OKAY;
            end
            default: state_nxt = DP_OKAY;
        endcase
    end

    // Only completing word data phases have side effects; errored ones never do.
    assign wr_fire = dp_valid & dp_word & HREADYMUX & dp_write;
    assign rd_fire = dp_valid & dp_word & HREADYMUX & ~dp_write;

    assign ctrl_wr  = wr_fire & (dp_addr == REG_CTRL);
    assign clr_wr   = wr_fire & (dp_addr == REG_CLR);

    assign tx_push  = wr_fire & (dp_addr == REG_DATA);
    assign tx_pop   = TXVALID & TXREADY;
    assign tx_flush = ctrl_wr & HWDATA[CTRL_TX_FLUSH];
    assign ovf_set  = tx_push & tx_full & ~tx_pop;

    assign rx_push    = RXVALID & RXREADY;
    assign rx_pop_req = rd_fire & (dp_addr == REG_DATA);
    assign rx_pop     = rx_pop_req & ~rx_empty;
    assign rx_flush   = ctrl_wr & HWDATA[CTRL_RX_FLUSH];
    assign unf_set    = rx_pop_req & rx_empty;

    assign TXVALID = ~tx_empty;
    assign RXREADY = ~rx_full;

    ahb_exp_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
        .clk       (FCLK),
        .rst_n     (MTXHRESETN),
        .push      (tx_push),
        .push_data (HWDATA[DATA_W-1:0]),
        .pop       (tx_pop),
        .flush     (tx_flush),
        .full      (tx_full),
        .empty     (tx_empty),
        .level     (tx_level),
        .head      (TXDATA)
    );

    ahb_exp_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
        .clk       (FCLK),
        .rst_n     (MTXHRESETN),
        .push      (rx_push),
        .push_data (RXDATA),
        .pop       (rx_pop),
        .flush     (rx_flush),
        .full      (rx_full),
        .empty     (rx_empty),
        .level     (rx_level),
        .head      (rx_head)
    );

    // Sticky flags: a new event in the same cycle as a W1C clear keeps the flag set.
    always_ff @(posedge FCLK or negedge MTXHRESETN) begin
        if (!MTXHRESETN) begin
            ctrl_rx_irq_en <= 1'b0;
            ctrl_tx_irq_en <= 1'b0;
            tx_ovf         <= 1'b0;
            rx_unf         <= 1'b0;
            IRQ            <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_rx_irq_en <= HWDATA[CTRL_RX_IRQ_EN];
                ctrl_tx_irq_en <= HWDATA[CTRL_TX_IRQ_EN];
            end
            if (ovf_set)                          tx_ovf <= 1'b1;
            else if (clr_wr && HWDATA[STAT_TX_OVF]) tx_ovf <= 1'b0;
            if (unf_set)                          rx_unf <= 1'b1;
            else if (clr_wr && HWDATA[STAT_RX_UNF]) rx_unf <= 1'b0;
            IRQ <= (ctrl_rx_irq_en & ~rx_empty) | (ctrl_tx_irq_en & tx_empty);
        end
    end

    always_comb begin
        stat_word                         = '0;
        stat_word[STAT_TX_FULL]           = tx_full;
        stat_word[STAT_TX_EMPTY]          = tx_empty;
        stat_word[STAT_RX_FULL]           = rx_full;
        stat_word[STAT_RX_EMPTY]          = rx_empty;
        stat_word[STAT_TX_OVF]            = tx_ovf;
        stat_word[STAT_RX_UNF]            = rx_unf;
        stat_word[STAT_TX_LVL +: 8]       = 8'(tx_level);
        stat_word[STAT_RX_LVL +: 8]       = 8'(rx_level);
    end

    always_comb begin
        HRDATA = '0;
        if (dp_valid && dp_word && !dp_write) begin
            case (dp_addr)
                REG_DATA: HRDATA = 32'(rx_head);
                REG_STAT: HRDATA = stat_word;
                REG_CTRL: begin
                    HRDATA[CTRL_RX_IRQ_EN] = ctrl_rx_irq_en;
                    HRDATA[CTRL_TX_IRQ_EN] = ctrl_tx_irq_en;
                end
                default:  HRDATA = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_exp_mailbox.sv
// Bench for the expansion-port mailbox: register vector table, FIFO stream
// scoreboards and hand-written reset, overflow, flush and pipelined sequences.
module tb_ahb_exp_mailbox;
    import ahb_exp_mailbox_pkg::*;

    logic        FCLK = 1'b0;
    logic        MTXHRESETN;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADYMUX;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        EXRESP;
    logic [2:0]  HRUSER;
    logic [31:0] TXDATA;
    logic        TXVALID;
    logic        TXREADY;
    logic [31:0] RXDATA;
    logic        RXVALID;
    logic        RXREADY;
    logic        IRQ;

    ahb_exp_mailbox dut (
        .FCLK(FCLK), .MTXHRESETN(MTXHRESETN), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADYMUX(HREADYMUX), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .EXRESP(EXRESP), .HRUSER(HRUSER), .TXDATA(TXDATA),
        .TXVALID(TXVALID), .TXREADY(TXREADY), .RXDATA(RXDATA),
        .RXVALID(RXVALID), .RXREADY(RXREADY), .IRQ(IRQ)
    );

    always #5 FCLK = ~FCLK;
    assign HREADYMUX = HREADYOUT;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    logic [31:0] rd_q[$];
    bit m_ovf, m_unf, m_rx_en, m_tx_en;
    bit tx_ready_dp = 0;
    bit rxvalid_dp = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [2:0]  sz;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        err;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] stat_exp();
        logic [31:0] s;
        s = '0;
        s[0] = (tx_q.size() == 16);
        s[1] = (tx_q.size() == 0);
        s[2] = (rx_q.size() == 16);
        s[3] = (rx_q.size() == 0);
        s[4] = m_ovf;
        s[5] = m_unf;
        s[15:8]  = 8'(tx_q.size());
        s[23:16] = 8'(rx_q.size());
        return s;
    endfunction

    function automatic logic irq_exp();
        return (m_rx_en && rx_q.size() != 0) || (m_tx_en && tx_q.size() == 0);
    endfunction

    function automatic logic [31:0] rx_front();
        return (rx_q.size() != 0) ? rx_q[0] : 32'h0;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin @(posedge FCLK); #1; end
    endtask

    // Model effect of a completed word access; a concurrent fabric push lands before a flush.
    task automatic model_update(input logic wr, input logic [1:0] a, input logic [31:0] wd);
        if (rxvalid_dp && rx_q.size() < 16) rx_q.push_back(32'hDEAD_0000);
        if (wr) begin
            case (a)
                REG_DATA: if (tx_q.size() < 16) tx_q.push_back(wd); else m_ovf = 1;
                REG_CTRL: begin
                    m_rx_en = wd[0];
                    m_tx_en = wd[1];
                    if (wd[2]) tx_q.delete();
                    if (wd[3]) rx_q.delete();
                end
                REG_CLR: begin
                    if (wd[4]) m_ovf = 0;
                    if (wd[5]) m_unf = 0;
                end
                default: ;
            endcase
        end else if (a == REG_DATA) begin
            if (rx_q.size() != 0) void'(rx_q.pop_front());
            else m_unf = 1;
        end
    endtask

    task automatic bus_xfer(input logic wr, input logic [1:0] a, input logic [2:0] sz,
                            input logic [31:0] wd, input logic [31:0] exp_rd,
                            input logic exp_err, input string nm);
        HSEL = 1; HTRANS = 2'b10; HWRITE = wr; HADDR = {28'h0, a, 2'b00}; HSIZE = sz;
        if (!wr && !exp_err) rd_q.push_back(exp_rd);
        @(posedge FCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = wd;
        if (tx_ready_dp) TXREADY = 1;
        if (rxvalid_dp) begin RXVALID = 1; RXDATA = 32'hDEAD_0000; end
        @(negedge FCLK);
        if (exp_err) begin
            chk({nm, " err1 rdy/resp"}, {30'h0, HREADYOUT, HRESP}, 32'h1);
            @(posedge FCLK); #1;
            @(negedge FCLK);
            chk({nm, " err2 rdy/resp"}, {30'h0, HREADYOUT, HRESP}, 32'h3);
        end else begin
            chk({nm, " okay rdy/resp"}, {30'h0, HREADYOUT, HRESP}, 32'h2);
            if (!wr) chk(nm, HRDATA, rd_q.pop_front());
        end
        @(posedge FCLK); #1;
        if (tx_ready_dp) TXREADY = 0;
        if (!exp_err) model_update(wr, a, wd);
        if (rxvalid_dp) RXVALID = 0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd, input string nm);
        bus_xfer(1, a, SIZE_WORD, wd, 32'h0, 0, nm);
    endtask

    task automatic rd_reg(input logic [1:0] a, input logic [31:0] exp, input string nm);
        bus_xfer(0, a, SIZE_WORD, 32'h0, exp, 0, nm);
    endtask

    task automatic fab_push(input logic [31:0] d);
        RXVALID = 1; RXDATA = d;
        @(negedge FCLK);
        chk("rxready", {31'h0, RXREADY}, (rx_q.size() < 16) ? 32'h1 : 32'h0);
        @(posedge FCLK); #1;
        if (rx_q.size() < 16) rx_q.push_back(d);
        RXVALID = 0;
    endtask

    // TX stream scoreboard: the fabric side must see exactly the accepted writes, in order.
    always @(negedge FCLK) begin
        if (MTXHRESETN === 1'b1) begin
            chk("txvalid", {31'h0, TXVALID}, (tx_q.size() != 0) ? 32'h1 : 32'h0);
            if (TXVALID && TXREADY) begin
                if (tx_q.size() == 0) chk("txdata unexpected", TXDATA, 32'hXXXX_XXXX);
                else chk("txdata", TXDATA, tx_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        MTXHRESETN = 0; HSEL = 0; HADDR = 0; HTRANS = 0; HWRITE = 0; HSIZE = 0;
        HWDATA = 0; TXREADY = 0; RXDATA = 0; RXVALID = 0;
        m_ovf = 0; m_unf = 0; m_rx_en = 0; m_tx_en = 0;

        vecs.push_back('{1'b0, REG_STAT, 3'b010, 32'h0, 32'h0000_000A, 1'b0});
        vecs.push_back('{1'b1, REG_CTRL, 3'b010, 32'h3, 32'h0, 1'b0});
        vecs.push_back('{1'b0, REG_CTRL, 3'b010, 32'h0, 32'h3, 1'b0});
        vecs.push_back('{1'b1, REG_CTRL, 3'b000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, REG_CTRL, 3'b010, 32'h0, 32'h3, 1'b0});
        vecs.push_back('{1'b1, REG_CTRL, 3'b001, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, REG_CTRL, 3'b010, 32'h0, 32'h3, 1'b0});
        vecs.push_back('{1'b1, REG_CTRL, 3'b010, 32'hF, 32'h0, 1'b0});
        vecs.push_back('{1'b0, REG_CTRL, 3'b010, 32'h0, 32'h3, 1'b0});
        vecs.push_back('{1'b0, REG_CLR,  3'b010, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, REG_DATA, 3'b010, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, REG_STAT, 3'b010, 32'h0, 32'h0000_002A, 1'b0});
        vecs.push_back('{1'b1, REG_CLR,  3'b010, 32'h20, 32'h0, 1'b0});
        vecs.push_back('{1'b0, REG_STAT, 3'b010, 32'h0, 32'h0000_000A, 1'b0});
        vecs.push_back('{1'b1, REG_CTRL, 3'b010, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, REG_CTRL, 3'b010, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, REG_DATA, 3'b000, 32'h0, 32'h0, 1'b1});
        vecs.push_back('{1'b0, REG_STAT, 3'b010, 32'h0, 32'h0000_000A, 1'b0});

        repeat (2) @(posedge FCLK);
        #1 MTXHRESETN = 1;
        idle(1);

        // Reset asserted in the middle of a write data phase.
        wr_reg(REG_DATA, 32'hA5A5_0000, "w_pre_reset");
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = 32'h0; HSIZE = SIZE_WORD;
        @(posedge FCLK); #1;
        HSEL = 0; HTRANS = 2'b00; HWDATA = 32'hA5A5_0001;
        #2 MTXHRESETN = 0;
        tx_q.delete(); rx_q.delete(); rd_q.delete();
        m_ovf = 0; m_unf = 0; m_rx_en = 0; m_tx_en = 0;
        #1;
        chk("rst hrdata",    HRDATA, 32'h0);
        chk("rst hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst hresp",     {31'h0, HRESP}, 32'h0);
        chk("rst txvalid",   {31'h0, TXVALID}, 32'h0);
        chk("rst rxready",   {31'h0, RXREADY}, 32'h1);
        chk("rst irq",       {31'h0, IRQ}, 32'h0);
        @(posedge FCLK); #1;
        MTXHRESETN = 1;
        idle(1);

        for (int i = 0; i < vecs.size(); i++) begin
            bus_xfer(vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].wd, vecs[i].exp_rd,
                     vecs[i].err, $sformatf("vec%0d", i));
            idle(1);
            chk($sformatf("vec%0d irq", i), {31'h0, IRQ}, {31'h0, irq_exp()});
        end

        // TX ordering with the fabric stalled, then drained.
        for (int i = 1; i <= 3; i++) wr_reg(REG_DATA, 32'hA5A5_0000 + i, "w_tx");
        rd_reg(REG_STAT, 32'h0000_0308, "stat_tx3");
        TXREADY = 1;
        idle(5);
        chk("txvalid fell", {31'h0, TXVALID}, 32'h0);
        TXREADY = 0;

        // Overflow on the 17th write, then W1C clear.
        for (int i = 0; i < 17; i++) wr_reg(REG_DATA, 32'hB000_0000 + i, "w_fill");
        rd_reg(REG_STAT, 32'h0000_1019, "stat_ovf");
        wr_reg(REG_CLR, 32'h10, "w_clr_ovf");
        rd_reg(REG_STAT, 32'h0000_1009, "stat_ovf_clr");

        // Full TX: each write's data phase coincides with a fabric pop, so nothing drops.
        tx_ready_dp = 1;
        for (int i = 0; i < 4; i++) wr_reg(REG_DATA, 32'hC000_0000 + i, "w_full_pop");
        tx_ready_dp = 0;
        rd_reg(REG_STAT, 32'h0000_1009, "stat_full_pop");
        wr_reg(REG_CTRL, 32'h4, "w_tx_flush");
        rd_reg(REG_STAT, 32'h0000_000A, "stat_tx_flush");

        // RX path and interrupt.
        fab_push(32'h1234_5678);
        wr_reg(REG_CTRL, 32'h1, "w_rx_irq_en");
        idle(1);
        chk("irq rx set", {31'h0, IRQ}, 32'h1);
        rd_reg(REG_DATA, 32'h1234_5678, "rd_rx");
        idle(1);
        chk("irq rx clr", {31'h0, IRQ}, 32'h0);
        rd_reg(REG_DATA, 32'h0, "rd_rx_empty");
        rd_reg(REG_STAT, 32'h0000_002A, "stat_unf");
        wr_reg(REG_CLR, 32'h20, "w_clr_unf");

        // RX flush in the same cycle as a fabric push: flush wins.
        fab_push(32'h5555_0001);
        rxvalid_dp = 1;
        wr_reg(REG_CTRL, 32'h8, "w_rx_flush");
        rxvalid_dp = 0;
        rd_reg(REG_STAT, 32'h0000_000A, "stat_rx_flush");

        // Fill RX to full; the 17th offer must see RXREADY low.
        for (int i = 0; i < 17; i++) fab_push(32'hE000_0000 + i);
        rd_reg(REG_STAT, 32'h0010_0006, "stat_rx_full");

        // Pipelined: DATA write, STAT read, DATA read back to back.
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {28'h0, REG_DATA, 2'b00}; HSIZE = SIZE_WORD;
        @(posedge FCLK); #1;
        HWDATA = 32'hBEEF_0001; HWRITE = 0; HADDR = {28'h0, REG_STAT, 2'b00};
        rd_q.push_back(32'h0010_0104);
        @(posedge FCLK); #1;
        tx_q.push_back(32'hBEEF_0001);
        HADDR = {28'h0, REG_DATA, 2'b00};
        rd_q.push_back(rx_front());
        @(negedge FCLK);
        chk("b2b stat", HRDATA, rd_q.pop_front());
        @(posedge FCLK); #1;
        HSEL = 0; HTRANS = 2'b00;
        @(negedge FCLK);
        chk("b2b data", HRDATA, rd_q.pop_front());
        @(posedge FCLK); #1;
        void'(rx_q.pop_front());
        rd_reg(REG_STAT, stat_exp(), "stat_after_b2b");
        chk("exresp/hruser", {28'h0, EXRESP, HRUSER}, 32'h0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
